nz_mux_sel_sequencer: RTL



---
 rtl/nz_mux_sel_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/nz_mux_sel_sequencer.sv
// Holds one brick of neuron values on the select-mux data inputs and walks its
// nonzero neurons in ascending index order, one select code per handshake beat.
module nz_mux_sel_sequencer #(
    parameter int BIT_WIDTH  = 16,
    parameter int SEL_WIDTH  = 4,
    parameter int NUM_INPUTS = 1 << SEL_WIDTH
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_brick_valid,
    output logic                            o_brick_ready,
    input  logic [BIT_WIDTH*NUM_INPUTS-1:0] i_brick,
    output logic [BIT_WIDTH*NUM_INPUTS-1:0] o_mux_in,
    output logic [SEL_WIDTH-1:0]            o_sel,
    output logic                            o_sel_valid,
    input  logic                            i_sel_ready,
    output logic                            o_last,
    output logic                            o_zero,
    output logic [SEL_WIDTH:0]              o_nz_count
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    localparam logic [NUM_INPUTS-1:0] MASK_ONE = NUM_INPUTS'(1);

    state_t                 state;
    state_t                 next_state;
    logic [NUM_INPUTS-1:0]  pending;
    logic [NUM_INPUTS-1:0]  pending_rest;
    logic [NUM_INPUTS-1:0]  brick_mask;
    logic [SEL_WIDTH:0]     brick_popcount;
    logic [SEL_WIDTH-1:0]   lowest_idx;
    logic                   one_left;
    logic                   zero_brick;
    logic                   accept;
    logic                   advance;

    // Full-width compare per neuron, so negative values count as work.
    always_comb begin
        brick_mask     = '0;
        brick_popcount = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            brick_mask[k]  = |i_brick[k*BIT_WIDTH +: BIT_WIDTH];
            brick_popcount = brick_popcount + (SEL_WIDTH+1)'(brick_mask[k]);
        end
    end

    // Scanning downward leaves the lowest pending index as the final winner.
    always_comb begin
        lowest_idx = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            if (pending[k]) begin
                lowest_idx = SEL_WIDTH'(k);
            end
        end
    end

    // Clearing the lowest set bit both retires the emitted beat and tells us
    // whether it was the only one left.
    assign pending_rest = pending & (pending - MASK_ONE);
    assign one_left     = (pending != '0) && (pending_rest == '0);

    assign accept  = (state == IDLE) && i_brick_valid;
    assign advance = (state == EMIT) && i_sel_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        o_brick_ready = 1'b0;
        o_sel_valid   = 1'b0;
        o_sel         = '0;
        o_last        = 1'b0;
        o_zero        = 1'b0;
        case (state)
            IDLE: begin
                o_brick_ready = 1'b1;
                if (i_brick_valid) begin
                    next_state = EMIT;
                end
            end
            EMIT: begin
                o_sel_valid = 1'b1;
                if (zero_brick) begin
                    o_zero = 1'b1;
                    o_last = 1'b1;
                end else begin
                    o_sel  = lowest_idx;
                    o_last = one_left;
                end
                if (i_sel_ready && o_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Brick data changes only on acceptance, keeping the mux inputs stable
    // for every beat of the brick.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_mux_in   <= '0;
            pending    <= '0;
            o_nz_count <= '0;
            zero_brick <= 1'b0;
        end else if (accept) begin
            o_mux_in   <= i_brick;
            pending    <= brick_mask;
            o_nz_count <= brick_popcount;
            zero_brick <= (brick_mask == '0);
        end else if (advance) begin
            pending    <= pending_rest;
        end
    end

endmodule
